pixel_line_tx: RTL and testbench

Pixel-stream transmitter that drives the camera-side pixel interface of the reflex pipeline: `valid_pixel`, `pixel_val`, `x_coord`, `end_of_line`. Pixels arrive from the host/DMA path over a ready/valid handshake into an internal FIFO. They are serialised into lines of programmable width, each closed by a one-cycle `end_of_line` pulse, with programmable horizontal blanking between lines. It is the source end of the stream that the symmetry monitor consumes.

---
 rtl/pixel_line_tx.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_pixel_line_tx.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_line_tx.sv
// pixel_line_tx
// -----------------------------------------------------------------------------
// Source end of the camera-side pixel stream. Pixels from the host/DMA path
// enter an internal FIFO over a ready/valid handshake and are serialised into
// lines of programmable width. Each line is closed by a one-cycle end_of_line
// pulse and followed by a programmable number of horizontal blanking cycles.
//
// Optional feature macro: PIXEL_TX_PATTERN_EN
//   When defined, pattern_sel (sampled at line start) replaces FIFO data with
//   a ramp pixel_val = x_coord[7:0]. The FIFO is not popped in that mode and
//   no underrun can occur. When undefined, pattern_sel is ignored.
//
// Ports
//   clk, rst_n          single rising-edge clock, async active-low reset
//   s_valid/s_data      upstream pixel handshake (transfer when s_valid && s_ready)
//   s_ready             FIFO not full
//   enable              start/continue line generation
//   line_width          pixels per line (0 holds the FSM in IDLE)
//   hblank              idle cycles after end_of_line before the next line
//   pattern_sel         ramp pattern select (pattern build only)
//   valid_pixel         pixel valid this cycle
//   pixel_val/x_coord   pixel value and 0-based column
//   end_of_line         one-cycle pulse closing a line
//   line_count          completed lines (wraps)
//   underrun            sticky: FIFO ran empty mid-line
//   clr_underrun        clears underrun (a new underrun wins)
// -----------------------------------------------------------------------------
module pixel_line_tx #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  input  logic        enable,
  input  logic [9:0]  line_width,
  input  logic [7:0]  hblank,
  input  logic        pattern_sel,
  output logic        valid_pixel,
  output logic [7:0]  pixel_val,
  output logic [9:0]  x_coord,
  output logic        end_of_line,
  output logic [15:0] line_count,
  output logic        underrun,
  input  logic        clr_underrun
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_EOL    = 2'd2,
    ST_BLANK  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic [AW:0]   count_next_s;
  logic          ready_r;
  logic          wr_en_s;
  logic          pop_s;
  logic          fifo_empty_s;
  logic [7:0]    fifo_rd_data_s;

  assign wr_en_s        = s_valid && ready_r;
  assign fifo_empty_s   = (count_r == {(AW+1){1'b0}});
  assign fifo_rd_data_s = mem_r[rd_ptr_r];
  assign s_ready        = ready_r;

  // Next FIFO occupancy from the write/pop pair; simultaneous ops cancel.
  always_comb begin
    count_next_s = count_r;
    case ({wr_en_s, pop_s})
      2'b10:   count_next_s = count_r + (AW+1)'(1);
      2'b01:   count_next_s = count_r - (AW+1)'(1);
      default: count_next_s = count_r;
    endcase
  end

  // FIFO storage; no reset needed, validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= s_data;
    end
  end

  // FIFO pointers, occupancy and the registered ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
      ready_r  <= 1'b1;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_next_s;
      ready_r <= (count_next_s != DEPTH_C);
    end
  end

  // ---------------------------------------------------------------------------
  // Line FSM
  // ---------------------------------------------------------------------------
  state_t      state_r;
  state_t      state_next_s;
  logic [9:0]  width_r;
  logic [9:0]  col_r;
  logic [7:0]  blank_cnt_r;
  logic        start_ok_s;
  logic        start_s;
  logic        emit_s;
  logic        eol_s;
  logic        blank_load_s;
  logic        underrun_set_s;
  logic        last_col_s;
  logic        pattern_mode_s;

  assign start_ok_s = enable && (line_width != 10'd0);
  assign last_col_s = (col_r == (width_r - 10'd1));

`ifdef PIXEL_TX_PATTERN_EN
  logic pattern_r;

  // Ramp mode is fixed for the whole line once it starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_r <= 1'b0;
    end else if (start_s) begin
      pattern_r <= pattern_sel;
    end else begin
      pattern_r <= pattern_r;
    end
  end

  assign pattern_mode_s = pattern_r;
`else
  logic pattern_unused;
  assign pattern_unused = pattern_sel;
  assign pattern_mode_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_next_s   = state_r;
    start_s        = 1'b0;
    emit_s         = 1'b0;
    pop_s          = 1'b0;
    eol_s          = 1'b0;
    blank_load_s   = 1'b0;
    underrun_set_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) begin
          start_s      = 1'b1;
          state_next_s = ST_ACTIVE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (pattern_mode_s) begin
          emit_s = 1'b1;
        end else if (!fifo_empty_s) begin
          emit_s = 1'b1;
          pop_s  = 1'b1;
        end else begin
          // Stall: column holds, the line is never truncated.
          underrun_set_s = 1'b1;
        end
        if (emit_s && last_col_s) begin
          state_next_s = ST_EOL;
        end else begin
          state_next_s = ST_ACTIVE;
        end
      end
      ST_EOL: begin
        eol_s = 1'b1;
        if (hblank != 8'd0) begin
          blank_load_s = 1'b1;
          state_next_s = ST_BLANK;
        end else if (start_ok_s) begin
          start_s      = 1'b1;
          state_next_s = ST_ACTIVE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_BLANK: begin
        if (blank_cnt_r != 8'd1) begin
          state_next_s = ST_BLANK;
        end else if (start_ok_s) begin
          start_s      = 1'b1;
          state_next_s = ST_ACTIVE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Line geometry: width latched at line start, column advanced per pixel,
  // blanking length sampled on entry to BLANK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_r     <= 10'd0;
      col_r       <= 10'd0;
      blank_cnt_r <= 8'd0;
    end else begin
      if (start_s) begin
        width_r <= line_width;
        col_r   <= 10'd0;
      end else if (emit_s) begin
        col_r <= col_r + 10'd1;
      end
      if (blank_load_s) begin
        blank_cnt_r <= hblank;
      end else if (state_r == ST_BLANK) begin
        blank_cnt_r <= blank_cnt_r - 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  logic        valid_pixel_r;
  logic [7:0]  pixel_val_r;
  logic [9:0]  x_coord_r;
  logic        end_of_line_r;
  logic [15:0] line_count_r;
  logic        underrun_r;

  // Pixel stream and line-end outputs; emit and EOL are exclusive states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_pixel_r <= 1'b0;
      pixel_val_r   <= 8'd0;
      x_coord_r     <= 10'd0;
      end_of_line_r <= 1'b0;
      line_count_r  <= 16'd0;
    end else begin
      valid_pixel_r <= emit_s;
      end_of_line_r <= eol_s;
      if (emit_s) begin
        x_coord_r   <= col_r;
        pixel_val_r <= pattern_mode_s ? col_r[7:0] : fifo_rd_data_s;
      end
      if (eol_s) begin
        line_count_r <= line_count_r + 16'd1;
      end
    end
  end

  // Sticky underrun; a new underrun outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_r <= 1'b0;
    end else if (underrun_set_s) begin
      underrun_r <= 1'b1;
    end else if (clr_underrun) begin
      underrun_r <= 1'b0;
    end else begin
      underrun_r <= underrun_r;
    end
  end

  assign valid_pixel = valid_pixel_r;
  assign pixel_val   = pixel_val_r;
  assign x_coord     = x_coord_r;
  assign end_of_line = end_of_line_r;
  assign line_count  = line_count_r;
  assign underrun    = underrun_r;

endmodule

// File: tb/tb_pixel_line_tx.sv
// Scoreboard bench for pixel_line_tx: stimulus pushes expected stream events,
// a negedge monitor pops and compares them whenever the DUT emits a pixel or
// an end_of_line pulse.
module tb_pixel_line_tx;

  typedef struct packed {
    logic       eol;
    logic [9:0] x;
    logic [7:0] v;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'd0;
  logic        s_ready;
  logic        enable = 1'b0;
  logic [9:0]  line_width = 10'd0;
  logic [7:0]  hblank = 8'd0;
  logic        pattern_sel = 1'b0;
  logic        valid_pixel;
  logic [7:0]  pixel_val;
  logic [9:0]  x_coord;
  logic        end_of_line;
  logic [15:0] line_count;
  logic        underrun;
  logic        clr_underrun = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_eol_cyc = -1;
  int exp_gap = -1;
  ev_t exp_q[$];

  pixel_line_tx #(.FIFO_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .enable(enable), .line_width(line_width),
    .hblank(hblank), .pattern_sel(pattern_sel), .valid_pixel(valid_pixel),
    .pixel_val(pixel_val), .x_coord(x_coord), .end_of_line(end_of_line),
    .line_count(line_count), .underrun(underrun), .clr_underrun(clr_underrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every emitted pixel / end_of_line against the queue.
  always @(negedge clk) begin
    ev_t act;
    ev_t e;
    if (rst_n && (valid_pixel || end_of_line)) begin
      if (valid_pixel && end_of_line) begin
        chk("pixel_and_eol_exclusive", 32'd1, 32'd0);
      end
      act.eol = end_of_line;
      act.x   = valid_pixel ? x_coord : 10'd0;
      act.v   = valid_pixel ? pixel_val : 8'd0;
      if (exp_q.size() == 0) begin
        chk("unexpected_output", {13'd0, act}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("stream", {13'd0, act}, {13'd0, e});
      end
      if (valid_pixel && x_coord == 10'd0 && exp_gap >= 0 && last_eol_cyc >= 0) begin
        chk("eol_to_next_pixel_gap", cyc - last_eol_cyc, exp_gap);
      end
      if (end_of_line) last_eol_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_px(input int x, input logic [7:0] v);
    ev_t e;
    e.eol = 1'b0;
    e.x   = 10'(x);
    e.v   = v;
    exp_q.push_back(e);
  endtask

  task automatic exp_eol();
    ev_t e;
    e = '0;
    e.eol = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic push(input logic [7:0] v);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = v;
    while (!s_ready && n < 200) begin
      tick();
      n++;
    end
    if (!s_ready) chk("push_timeout", 32'd0, 32'd1);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic pulse_enable();
    enable = 1'b1;
    tick();
    enable = 1'b0;
  endtask

  task automatic wait_pixel(input int x, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!(valid_pixel && x_coord == 10'(x)) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!(valid_pixel && x_coord == 10'(x))) chk("wait_pixel_timeout", 32'(x_coord), 32'(x));
  endtask

  task automatic wait_lines(input int cnt, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (line_count != 16'(cnt) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (line_count != 16'(cnt)) chk("wait_lines_timeout", 32'(line_count), 32'(cnt));
  endtask

  task automatic clear_underrun();
    clr_underrun = 1'b1;
    tick();
    clr_underrun = 1'b0;
  endtask

  initial begin
    // Reset values
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_valid_pixel", 32'(valid_pixel), 32'd0);
    chk("rst_end_of_line", 32'(end_of_line), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_pixel_val", 32'(pixel_val), 32'd0);
    chk("rst_x_coord", 32'(x_coord), 32'd0);
    chk("rst_line_count", 32'(line_count), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);

    // Basic line: two 4-pixel lines, hblank 2
    line_width = 10'd4;
    hblank = 8'd2;
    exp_gap = 3;
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    for (int i = 0; i < 4; i++) exp_px(i, 8'h10 + 8'(i));
    exp_eol();
    for (int i = 0; i < 4; i++) exp_px(i, 8'h14 + 8'(i));
    exp_eol();
    enable = 1'b1;
    wait_lines(1, 50);
    wait_pixel(0, 20);
    enable = 1'b0;
    repeat (15) tick();
    exp_gap = -1;
    chk("basic_line_count", 32'(line_count), 32'd2);
    chk("basic_underrun", 32'(underrun), 32'd0);
    chk("basic_drained", exp_q.size(), 32'd0);

    // Underrun: 8-pixel line with 5 pixels, then 3 more
    line_width = 10'd8;
    hblank = 8'd0;
    for (int i = 0; i < 5; i++) push(8'h20 + 8'(i));
    for (int i = 0; i < 8; i++) exp_px(i, 8'h20 + 8'(i));
    exp_eol();
    pulse_enable();
    repeat (10) tick();
    chk("underrun_set", 32'(underrun), 32'd1);
    chk("underrun_stalled_valid", 32'(valid_pixel), 32'd0);
    chk("underrun_held_x", 32'(x_coord), 32'd4);
    push(8'h25);
    chk("latency_t1_not_yet", 32'(valid_pixel), 32'd0);
    tick();
    chk("latency_t2_valid", 32'(valid_pixel), 32'd1);
    chk("latency_t2_x", 32'(x_coord), 32'd5);
    push(8'h26);
    push(8'h27);
    repeat (8) tick();
    chk("underrun_line_count", 32'(line_count), 32'd3);
    chk("underrun_sticky", 32'(underrun), 32'd1);
    clear_underrun();
    chk("underrun_cleared", 32'(underrun), 32'd0);

    // Backpressure: fill FIFO with enable low
    line_width = 10'd16;
    for (int i = 0; i < 16; i++) push(8'h40 + 8'(i));
    chk("full_s_ready", 32'(s_ready), 32'd0);
    s_valid = 1'b1;
    s_data = 8'hEE;
    repeat (3) tick();
    s_valid = 1'b0;
    chk("full_still_not_ready", 32'(s_ready), 32'd0);
    for (int i = 0; i < 16; i++) exp_px(i, 8'h40 + 8'(i));
    exp_eol();
    pulse_enable();
    repeat (25) tick();
    chk("bp_line_count", 32'(line_count), 32'd4);
    chk("bp_s_ready_back", 32'(s_ready), 32'd1);
    chk("bp_no_underrun", 32'(underrun), 32'd0);

    // Mid-line changes: drop enable and shrink width at x=2
    line_width = 10'd6;
    hblank = 8'd1;
    for (int i = 0; i < 9; i++) push(8'h60 + 8'(i));
    for (int i = 0; i < 6; i++) exp_px(i, 8'h60 + 8'(i));
    exp_eol();
    enable = 1'b1;
    wait_pixel(2, 30);
    enable = 1'b0;
    line_width = 10'd3;
    repeat (15) tick();
    chk("midline_line_count", 32'(line_count), 32'd5);
    chk("midline_idle_drained", exp_q.size(), 32'd0);
    for (int i = 0; i < 3; i++) exp_px(i, 8'h66 + 8'(i));
    exp_eol();
    pulse_enable();
    repeat (10) tick();
    chk("short_line_count", 32'(line_count), 32'd6);

    // Reset mid-line at x=3
    line_width = 10'd8;
    for (int i = 0; i < 8; i++) push(8'h80 + 8'(i));
    for (int i = 0; i < 4; i++) exp_px(i, 8'h80 + 8'(i));
    enable = 1'b1;
    wait_pixel(3, 30);
    #2;
    rst_n = 1'b0;
    #1;
    enable = 1'b0;
    chk("arst_valid_pixel", 32'(valid_pixel), 32'd0);
    chk("arst_x_coord", 32'(x_coord), 32'd0);
    chk("arst_pixel_val", 32'(pixel_val), 32'd0);
    chk("arst_line_count", 32'(line_count), 32'd0);
    chk("arst_end_of_line", 32'(end_of_line), 32'd0);
    chk("arst_s_ready", 32'(s_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    // FIFO must be empty after reset: a 1-pixel line stalls until new data.
    line_width = 10'd1;
    hblank = 8'd0;
    pulse_enable();
    repeat (5) tick();
    chk("arst_fifo_discarded", 32'(underrun), 32'd1);
    exp_px(0, 8'h99);
    exp_eol();
    push(8'h99);
    repeat (6) tick();
    chk("arst_after_line_count", 32'(line_count), 32'd1);

`ifdef PIXEL_TX_PATTERN_EN
    // Ramp pattern, FIFO empty, 300 pixels with wrap at x=256
    clear_underrun();
    pattern_sel = 1'b1;
    line_width = 10'd300;
    for (int i = 0; i < 300; i++) exp_px(i, 8'(i));
    exp_eol();
    pulse_enable();
    pattern_sel = 1'b0;
    wait_lines(2, 400);
    chk("pattern_no_underrun", 32'(underrun), 32'd0);
`endif

    repeat (5) tick();
    chk("final_queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
